// File: rtl/guvm_instr_feeder.sv
// Instruction-side responder: buffers driver-pushed words and answers
// core fetches after a programmable grant delay, NOP when starved.
module guvm_instr_feeder #(
  parameter int DEPTH = 8,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_valid_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic              push_ready_o,
  input  logic [3:0]        stall_cycles_i,
  input  logic              instr_req_i,
  input  logic [31:0]       instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [DATA_W-1:0] instr_rdata_o,
  output logic [31:0]       fetch_addr_o,
  output logic [15:0]       fetch_count_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic              empty_o,
  output logic              proto_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_WAIT = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [LW-1:0]     level_q;
  logic              rdy_q;
  logic              state_q;
  logic              state_d;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic              err_set;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              gnt;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // ready is held low until the first edge after reset release
  assign push_ready_o = rdy_q && !full;
  assign push = push_valid_i && push_ready_o;
  assign pop  = gnt && !empty;

  assign instr_gnt_o = gnt;
  assign level_o     = level_q;
  assign empty_o     = empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    err_set = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (instr_req_i) begin
          if (stall_cycles_i == 4'd0) begin
            gnt = 1'b1;
          end else begin
            cnt_d   = stall_cycles_i - 4'd1;
            state_d = S_WAIT;
          end
        end
      end
      (state_q == S_WAIT): begin
        if (!instr_req_i) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          gnt     = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr_q] <= push_data_i;
    end
  end

  // pop reads the pre-edge head, so a same-cycle push into an empty FIFO
  // is never bypassed to the core
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_rvalid_o <= 1'b0;
      instr_rdata_o  <= NOP_INSTR;
      fetch_addr_o   <= 32'd0;
      fetch_count_o  <= 16'd0;
      proto_err_o    <= 1'b0;
    end else begin
      instr_rvalid_o <= gnt;
      if (gnt) begin
        instr_rdata_o <= empty ? NOP_INSTR : mem[rptr_q];
        fetch_addr_o  <= instr_addr_i;
        fetch_count_o <= fetch_count_o + 16'd1;
      end
      if (err_set) begin
        proto_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_guvm_instr_feeder.sv
// Bench for guvm_instr_feeder: directed scenarios plus random traffic
// checked against a queue-based fetch model.
module tb_guvm_instr_feeder;

  localparam int DEPTH = 8;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid;
  logic [31:0] push_data;
  logic        push_ready;
  logic [3:0]  stall;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] faddr;
  logic [15:0] fcount;
  logic [3:0]  level;
  logic        empty;
  logic        perr;

  always #5 clk = ~clk;

  guvm_instr_feeder dut (
    .clk_i(clk), .rst_i(rst),
    .push_valid_i(push_valid), .push_data_i(push_data),
    .push_ready_o(push_ready), .stall_cycles_i(stall),
    .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt), .instr_rvalid_o(rvalid),
    .instr_rdata_o(rdata), .fetch_addr_o(faddr),
    .fetch_count_o(fcount), .level_o(level),
    .empty_o(empty), .proto_err_o(perr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mq[$];
  bit          m_rdy;
  bit          m_pend;
  bit          m_rv;
  bit          m_perr;
  int          m_start;
  int          m_s;
  int          m_cyc;
  logic [31:0] m_rdata;
  logic [31:0] m_faddr;
  logic [15:0] m_fcnt;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_gnt();
    if (!req) return 1'b0;
    if (m_pend) return (m_cyc - m_start) == m_s;
    return stall == 4'd0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rdy   = 1'b0;
    m_pend  = 1'b0;
    m_rv    = 1'b0;
    m_perr  = 1'b0;
    m_cyc   = 0;
    m_rdata = NOP;
    m_faddr = 32'd0;
    m_fcnt  = 16'd0;
  endtask

  task automatic reset_checks();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, NOP);
    check("rst_faddr", faddr, 32'd0);
    check("rst_fcount", 32'(fcount), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_perr", 32'(perr), 32'd0);
    check("rst_ready", 32'(push_ready), 32'd0);
  endtask

  task automatic idle_inputs();
    push_valid = 1'b0;
    push_data  = 32'd0;
    req        = 1'b0;
    stall      = 4'd0;
    addr       = 32'd0;
  endtask

  // asserted mid-cycle so the asynchronous clear is observed before any edge
  task automatic async_reset();
    rst = 1'b1;
    #1;
    reset_checks();
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step();
    bit g;
    bit acc;
    @(negedge clk);
    check("ready", 32'(push_ready), 32'(m_rdy && mq.size() < DEPTH));
    check("level", 32'(level), 32'(mq.size()));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("rvalid", 32'(rvalid), 32'(m_rv));
    check("rdata", rdata, m_rdata);
    check("fcount", 32'(fcount), 32'(m_fcnt));
    check("faddr", faddr, m_faddr);
    check("perr", 32'(perr), 32'(m_perr));
    g = exp_gnt();
    check("gnt", 32'(gnt), 32'(g));
    acc = push_valid && m_rdy && mq.size() < DEPTH;
    if (g) begin
      m_rdata = (mq.size() > 0) ? mq.pop_front() : NOP;
      m_fcnt  = m_fcnt + 16'd1;
      m_faddr = addr;
    end
    if (acc) mq.push_back(push_data);
    if (req) begin
      if (m_pend) begin
        if (g) m_pend = 1'b0;
      end else if (stall != 4'd0) begin
        m_pend  = 1'b1;
        m_start = m_cyc;
        m_s     = int'(stall);
      end
    end else if (m_pend) begin
      m_perr = 1'b1;
      m_pend = 1'b0;
    end
    m_rv = g;
    m_rdy = 1'b1;
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    reset_checks();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // three words, back-to-back grants
    step();
    push_valid = 1'b1;
    push_data = 32'hA0A0_0001; step();
    push_data = 32'hB0B0_0002; step();
    push_data = 32'hC0C0_0003; step();
    push_valid = 1'b0;
    req = 1'b1; stall = 4'd0;
    for (int i = 0; i < 3; i++) begin
      addr = 32'h100 + 32'(4 * i);
      step();
    end
    req = 1'b0;
    step();
    check("abc_count", 32'(fcount), 32'd3);
    check("abc_empty", 32'(empty), 32'd1);
    check("abc_last", rdata, 32'hC0C0_0003);

    // delayed grant; stall changes mid-wait must be ignored
    req = 1'b1; stall = 4'd3; addr = 32'h80;
    step();
    stall = 4'd0;
    step(); step(); step();
    req = 1'b0;
    step(); step();
    check("stall_faddr", faddr, 32'h80);

    // starved fetch
    req = 1'b1; stall = 4'd0; addr = 32'h200;
    step();
    req = 1'b0;
    step();
    check("nop_rdata", rdata, NOP);
    check("nop_level", 32'(level), 32'd0);

    // fill, refused ninth push during a pop, then drain
    push_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push_data = 32'h1000 + 32'(i);
      step();
    end
    check("full_ready", 32'(push_ready), 32'd0);
    check("full_level", 32'(level), 32'd8);
    push_data = 32'h1009; req = 1'b1; stall = 4'd0;
    step();
    push_valid = 1'b0; req = 1'b0;
    step();
    check("full_first", rdata, 32'h1001);
    req = 1'b1;
    repeat (8) step();
    req = 1'b0;
    step();
    check("drain_level", 32'(level), 32'd0);

    // dropped request sets sticky error, later fetch still works
    req = 1'b1; stall = 4'd2;
    step();
    req = 1'b0;
    step(); step();
    check("perr_set", 32'(perr), 32'd1);
    req = 1'b1; stall = 4'd1; addr = 32'h300;
    step(); step();
    req = 1'b0;
    step();
    check("perr_sticky", 32'(perr), 32'd1);
    check("after_err_faddr", faddr, 32'h300);

    // reset while waiting with words queued
    push_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_data = 32'h5000 + 32'(i);
      step();
    end
    push_valid = 1'b0;
    req = 1'b1; stall = 4'd5;
    step(); step();
    #1;
    async_reset();
    step();
    step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      push_valid = 1'($urandom_range(0, 1));
      push_data  = $urandom;
      if (m_pend) req = ($urandom_range(0, 15) != 0);
      else req = 1'($urandom_range(0, 1));
      stall = 4'($urandom_range(0, 4));
      addr  = $urandom;
      step();
      if (c == 1500) begin
        #1;
        async_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
